// File: rtl/key_entry_scan.sv
// 4x4 keypad scanner with frame debounce and two-field (A/B) decimal entry FSM.
// Build option: define KEY_ZERO_REJECT_EN to make enter with an empty (zero) buffer a no-op.
module key_entry_scan #(
  parameter int F   = 50_000,
  parameter int DEB = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [7:0] num1,
  output logic [7:0] num2,
  output logic       wr_done,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [7:0] edit_val,
  output logic [1:0] edit_sel
);

  localparam int CW = (F > 1) ? $clog2(F) : 1;
  localparam int MW = (DEB > 1) ? $clog2(DEB + 1) : 1;
  localparam logic [CW-1:0] STEP_LAST   = CW'(F - 1);
  localparam logic [CW-1:0] STEP_SAMPLE = CW'(F - 2);
  localparam logic [CW-1:0] ONE_C       = CW'(1);
  localparam logic [MW-1:0] DEB_M       = MW'(DEB);
  localparam logic [MW-1:0] ONE_M       = MW'(1);

  localparam logic [3:0] KEY_A     = 4'd10;
  localparam logic [3:0] KEY_B     = 4'd11;
  localparam logic [3:0] KEY_CLEAR = 4'd12;
  localparam logic [3:0] KEY_ENTER = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EDIT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  function automatic logic [4:0] pop16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [3:0] idx16(input logic [15:0] v);
    logic [3:0] k;
    k = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        k = 4'(i);
      end else begin
        k = k;
      end
    end
    return k;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] c;
    case (col)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      4'b0111: c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  logic [3:0]    row_meta_r, row_sync_r;
  logic [CW-1:0] step_cnt_r;
  logic [3:0]    key_col_r;
  logic [15:0]   raw_cur_r, prev_raw_r, stable_r;
  logic [MW-1:0] match_cnt_r;
  logic          key_valid_r;
  logic [3:0]    key_code_r;
  state_t        state_r, state_nxt_s;
  logic [7:0]    num1_r, num2_r, edit_val_r;
  logic [1:0]    edit_sel_r;
  logic          wr_done_r;

  logic [1:0]    col_idx_s;
  logic          sample_s, frame_end_s, commit_s, accept_s;
  logic [15:0]   raw_frame_s, press_s;
  logic [MW-1:0] match_nxt_s;
  logic [4:0]    press_cnt_s;
  logic [3:0]    press_idx_s;
  logic [7:0]    num1_nxt_s, num2_nxt_s, edit_val_nxt_s;
  logic [1:0]    edit_sel_nxt_s;
  logic          wr_done_nxt_s;

  // Scan timing and debounce decisions for the current cycle.
  always_comb begin
    col_idx_s   = col_index(key_col_r);
    sample_s    = (step_cnt_r == STEP_SAMPLE);
    frame_end_s = sample_s && (col_idx_s == 2'd3);
    raw_frame_s = raw_cur_r;
    raw_frame_s[15:12] = ~row_sync_r;
    if (raw_frame_s == prev_raw_r) begin
      match_nxt_s = (match_cnt_r >= DEB_M) ? DEB_M : (match_cnt_r + ONE_M);
    end else begin
      match_nxt_s = ONE_M;
    end
    commit_s    = frame_end_s && (match_nxt_s >= DEB_M);
    press_s     = raw_frame_s & ~stable_r;
    press_cnt_s = pop16(press_s);
    press_idx_s = idx16(press_s);
    accept_s    = commit_s && (press_cnt_s == 5'd1) && (press_idx_s < 4'd14);
  end

  // Row synchronizer, column rotation, raw frame capture and stable-map commit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_meta_r  <= 4'hF;
      row_sync_r  <= 4'hF;
      step_cnt_r  <= {CW{1'b0}};
      key_col_r   <= 4'b1110;
      raw_cur_r   <= 16'h0000;
      prev_raw_r  <= 16'h0000;
      stable_r    <= 16'h0000;
      match_cnt_r <= {MW{1'b0}};
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
    end else begin
      row_meta_r <= key_row;
      row_sync_r <= row_meta_r;
      if (step_cnt_r == STEP_LAST) begin
        step_cnt_r <= {CW{1'b0}};
        key_col_r  <= {key_col_r[2:0], key_col_r[3]};
      end else begin
        step_cnt_r <= step_cnt_r + ONE_C;
      end
      if (sample_s) begin
        raw_cur_r[{col_idx_s, 2'b00} +: 4] <= ~row_sync_r;
      end
      if (frame_end_s) begin
        prev_raw_r  <= raw_frame_s;
        match_cnt_r <= match_nxt_s;
      end
      if (commit_s) begin
        stable_r <= raw_frame_s;
      end
      key_valid_r <= accept_s;
      if (accept_s) begin
        key_code_r <= press_idx_s;
      end
    end
  end

  // Entry FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Entry FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (key_valid_r && (key_code_r == KEY_A || key_code_r == KEY_B)) begin
          state_nxt_s = S_EDIT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_EDIT: begin
        if (key_valid_r && key_code_r == KEY_ENTER) begin
`ifdef KEY_ZERO_REJECT_EN
          state_nxt_s = (edit_val_r == 8'd0) ? S_EDIT : S_WRITE;
`else
          state_nxt_s = S_WRITE;
`endif
        end else begin
          state_nxt_s = S_EDIT;
        end
      end
      S_WRITE: state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Entry FSM output logic: next values of the registered outputs.
  always_comb begin
    num1_nxt_s     = num1_r;
    num2_nxt_s     = num2_r;
    edit_val_nxt_s = edit_val_r;
    edit_sel_nxt_s = edit_sel_r;
    wr_done_nxt_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (key_valid_r && key_code_r == KEY_A) begin
          edit_sel_nxt_s = 2'b01;
          edit_val_nxt_s = 8'd0;
        end else if (key_valid_r && key_code_r == KEY_B) begin
          edit_sel_nxt_s = 2'b10;
          edit_val_nxt_s = 8'd0;
        end else begin
          edit_sel_nxt_s = edit_sel_r;
        end
      end
      S_EDIT: begin
        if (key_valid_r) begin
          case (key_code_r)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
              // Shift in the new digit, keeping only the last two.
              edit_val_nxt_s = (edit_val_r % 8'd10) * 8'd10 + {4'd0, key_code_r};
            KEY_A: begin
              edit_sel_nxt_s = 2'b01;
              edit_val_nxt_s = 8'd0;
            end
            KEY_B: begin
              edit_sel_nxt_s = 2'b10;
              edit_val_nxt_s = 8'd0;
            end
            KEY_CLEAR: edit_val_nxt_s = 8'd0;
            KEY_ENTER: begin
              if (state_nxt_s == S_WRITE) begin
                wr_done_nxt_s = 1'b1;
                if (edit_sel_r == 2'b01) begin
                  num1_nxt_s = edit_val_r;
                end else if (edit_sel_r == 2'b10) begin
                  num2_nxt_s = edit_val_r;
                end else begin
                  num1_nxt_s = num1_r;
                end
              end else begin
                wr_done_nxt_s = 1'b0;
              end
            end
            default: edit_val_nxt_s = edit_val_r;
          endcase
        end else begin
          edit_val_nxt_s = edit_val_r;
        end
      end
      S_WRITE: begin
        edit_val_nxt_s = 8'd0;
        edit_sel_nxt_s = 2'b00;
      end
      default: begin
        edit_val_nxt_s = 8'd0;
        edit_sel_nxt_s = 2'b00;
      end
    endcase
  end

  // Entry FSM output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      num1_r     <= 8'd0;
      num2_r     <= 8'd0;
      edit_val_r <= 8'd0;
      edit_sel_r <= 2'b00;
      wr_done_r  <= 1'b0;
    end else begin
      num1_r     <= num1_nxt_s;
      num2_r     <= num2_nxt_s;
      edit_val_r <= edit_val_nxt_s;
      edit_sel_r <= edit_sel_nxt_s;
      wr_done_r  <= wr_done_nxt_s;
    end
  end

  assign key_col   = key_col_r;
  assign num1      = num1_r;
  assign num2      = num2_r;
  assign wr_done   = wr_done_r;
  assign key_valid = key_valid_r;
  assign key_code  = key_code_r;
  assign edit_val  = edit_val_r;
  assign edit_sel  = edit_sel_r;

endmodule

// File: tb/tb_key_entry_scan.sv
// Scoreboard bench for key_entry_scan (F=8, DEB=2) with a behavioural keypad matrix.
`timescale 1ns/1ps
module tb_key_entry_scan;

  localparam int F     = 8;
  localparam int FRAME = 4 * F;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [7:0] num1, num2, edit_val;
  logic       wr_done, key_valid;
  logic [3:0] key_code;
  logic [1:0] edit_sel;
  logic [15:0] keys = 16'h0000;

  int tests = 0;
  int fails = 0;

  typedef struct packed {logic [3:0] code; logic [1:0] sel; logic [7:0] val;} kv_t;
  typedef struct packed {logic [7:0] n1; logic [7:0] n2;} wr_t;
  kv_t kv_q[$];
  wr_t wr_q[$];

  key_entry_scan #(.F(F), .DEB(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_row(key_row), .key_col(key_col),
    .num1(num1), .num2(num2), .wr_done(wr_done), .key_valid(key_valid),
    .key_code(key_code), .edit_val(edit_val), .edit_sel(edit_sel)
  );

  always #5 sys_clk = ~sys_clk;

  // Keypad matrix: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    key_row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!key_col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[c*4+r]) key_row[r] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_col"}, key_col, 4'b1110);
    check({tag, "_num1"}, num1, 8'd0);
    check({tag, "_num2"}, num2, 8'd0);
    check({tag, "_wr_done"}, wr_done, 1'b0);
    check({tag, "_key_valid"}, key_valid, 1'b0);
    check({tag, "_key_code"}, key_code, 4'd0);
    check({tag, "_edit_val"}, edit_val, 8'd0);
    check({tag, "_edit_sel"}, edit_sel, 2'b00);
  endtask

  // Press key k for 6 frames; if an event is expected, queue its code and resulting sel/val.
  task automatic press(input logic [3:0] k, input bit exp_kv, input logic [1:0] s, input logic [7:0] v);
    kv_t e;
    if (exp_kv) begin
      e.code = k; e.sel = s; e.val = v;
      kv_q.push_back(e);
    end
    keys = 16'h0000;
    keys[k] = 1'b1;
    wait_cycles(6 * FRAME);
    keys = 16'h0000;
    wait_cycles(4 * FRAME);
  endtask

  task automatic expect_write(input logic [7:0] n1, input logic [7:0] n2);
    wr_t w;
    w.n1 = n1; w.n2 = n2;
    wr_q.push_back(w);
  endtask

  // Monitor: pops expectations whenever the DUT pulses key_valid or wr_done.
  initial begin
    kv_t kv_cur;
    wr_t wr_cur;
    bit  kv_chk, wr_post;
    kv_chk = 1'b0;
    wr_post = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        kv_chk = 1'b0;
        wr_post = 1'b0;
      end else begin
        if (kv_chk) begin
          check("post_key_edit_sel", edit_sel, kv_cur.sel);
          check("post_key_edit_val", edit_val, kv_cur.val);
          kv_chk = 1'b0;
        end
        if (wr_post) begin
          check("post_write_edit_sel", edit_sel, 2'b00);
          check("post_write_edit_val", edit_val, 8'd0);
          wr_post = 1'b0;
        end
        if (key_valid) begin
          if (kv_q.size() == 0) begin
            check("spurious_key_valid", key_valid, 1'b0);
          end else begin
            kv_cur = kv_q.pop_front();
            check("key_code", key_code, kv_cur.code);
            kv_chk = 1'b1;
          end
        end
        if (wr_done) begin
          if (wr_q.size() == 0) begin
            check("spurious_wr_done", wr_done, 1'b0);
          end else begin
            wr_cur = wr_q.pop_front();
            check("write_num1", num1, wr_cur.n1);
            check("write_num2", num2, wr_cur.n2);
            wr_post = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] exp_col;
    wait_cycles(3);
    check_reset_outputs("reset");
    sys_rst_n = 1'b1;
    exp_col = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      wait_cycles(F);
      exp_col = {exp_col[2:0], exp_col[3]};
      check("col_rotate", key_col, exp_col);
    end
    wait_cycles(3 * FRAME);
    check("idle_num1", num1, 8'd0);
    check("idle_edit_sel", edit_sel, 2'b00);
    check("idle_key_code", key_code, 4'd0);

    // Field A entry: A,1,2,3,enter -> num1=23.
    press(4'd10, 1'b1, 2'b01, 8'd0);
    press(4'd1,  1'b1, 2'b01, 8'd1);
    press(4'd2,  1'b1, 2'b01, 8'd12);
    press(4'd3,  1'b1, 2'b01, 8'd23);
    expect_write(8'd23, 8'd0);
    press(4'd13, 1'b1, 2'b01, 8'd23);
    check("num1_after_A", num1, 8'd23);
    check("num2_after_A", num2, 8'd0);

    // Field B entry: B,7,clear,4,enter -> num2=4.
    press(4'd11, 1'b1, 2'b10, 8'd0);
    press(4'd7,  1'b1, 2'b10, 8'd7);
    press(4'd12, 1'b1, 2'b10, 8'd0);
    press(4'd4,  1'b1, 2'b10, 8'd4);
    expect_write(8'd23, 8'd4);
    press(4'd13, 1'b1, 2'b10, 8'd4);

    // Digit in idle: event only, no value change; key_code held afterwards.
    press(4'd2, 1'b1, 2'b00, 8'd0);
    check("key_code_held", key_code, 4'd2);
    check("num1_unchanged", num1, 8'd23);
    check("num2_unchanged", num2, 8'd4);

    // Bounce on key 5: alternate each frame for 3 frames, then hold -> single event.
    kv_q.push_back(kv_t'({4'd5, 2'b00, 8'd0}));
    for (int i = 0; i < 3; i++) begin
      keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      wait_cycles(FRAME);
    end
    keys = 16'h0020;
    wait_cycles(6 * FRAME);
    keys = 16'h0000;
    wait_cycles(4 * FRAME);

    // Two keys (3 and 5) together -> no event; key 14 alone -> ignored.
    keys = 16'h0028;
    wait_cycles(6 * FRAME);
    keys = 16'h0000;
    wait_cycles(4 * FRAME);
    press(4'd14, 1'b0, 2'b00, 8'd0);
    check("key_code_after_ignored", key_code, 4'd5);

    // Enter with an empty buffer.
    press(4'd11, 1'b1, 2'b10, 8'd0);
`ifdef KEY_ZERO_REJECT_EN
    press(4'd13, 1'b1, 2'b10, 8'd0);
    check("zero_reject_sel", edit_sel, 2'b10);
    check("zero_reject_num2", num2, 8'd4);
`else
    expect_write(8'd23, 8'd0);
    press(4'd13, 1'b1, 2'b10, 8'd0);
    check("zero_write_num2", num2, 8'd0);
    check("zero_write_sel", edit_sel, 2'b00);
`endif

    // Reset in the middle of an entry.
    press(4'd10, 1'b1, 2'b01, 8'd0);
    press(4'd9,  1'b1, 2'b01, 8'd9);
    check("mid_entry_val", edit_val, 8'd9);
    keys[6] = 1'b1;
    wait_cycles(F + 3);
    #2 sys_rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    keys = 16'h0000;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_cycles(F);
    check("restart_col", key_col, 4'b1101);
    wait_cycles(4 * FRAME);
    check("post_reset_num1", num1, 8'd0);
    check("post_reset_sel", edit_sel, 2'b00);
    check("kv_queue_drained", kv_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
